// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// Two-requester round-robin arbiter that drives the select pin of a 2:1 mux.
// A source keeps the mux while it requests. It can hold it for at most
// HOLD_MAX consecutive cycles while the other source is also requesting.
// Optional feature macro: ARB_LOCK_EN. When defined, it adds the `lock`
// input, which suppresses forced rotation while it is high.
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles under contention (2..255)
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [1:0] level-sensitive requests, req[i] for source i
//   lock   in   (ARB_LOCK_EN only) holds the current owner under contention
//   gnt    out  [1:0] one-hot grant, registered, 00 when idle
//   sel    out  mux select, registered, index of current or most recent owner
//   busy   out  registered |gnt
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy
);

  localparam int CNT_W = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  state_t           other_s;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [CNT_W-1:0] next_cnt_s;
  logic             last_r;
  logic             own_req_s;
  logic             oth_req_s;
  logic             at_limit_s;
  logic             rot_en_s;

  // Request and state views used by both owner states
  assign own_req_s  = (state_r == ST_OWN1) ? req[1] : req[0];
  assign oth_req_s  = (state_r == ST_OWN1) ? req[0] : req[1];
  assign other_s    = (state_r == ST_OWN1) ? ST_OWN0 : ST_OWN1;
  assign at_limit_s = (hold_cnt_r == HOLD_LAST);

`ifdef ARB_LOCK_EN
  assign rot_en_s = ~lock;
`else
  assign rot_en_s = 1'b1;
`endif

  // Next-state and hold counter decision
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = {CNT_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (req == 2'b01) begin
          next_state_s = ST_OWN0;
        end else if (req == 2'b10) begin
          next_state_s = ST_OWN1;
        end else if (req == 2'b11) begin
          // A tie goes to the source that did not own the mux last
          next_state_s = last_r ? ST_OWN0 : ST_OWN1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_req_s) begin
          // Release; hand over directly when the other side is waiting
          next_state_s = oth_req_s ? other_s : ST_IDLE;
        end else if (oth_req_s && rot_en_s && at_limit_s) begin
          next_state_s = other_s;
        end else begin
          // Keep ownership; the counter saturates so that a late
          // request from the other side rotates on the following edge
          next_state_s = state_r;
          next_cnt_s   = at_limit_s ? hold_cnt_r : (hold_cnt_r + CNT_W'(1));
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, priority pointer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= {CNT_W{1'b0}};
      last_r     <= 1'b1;
      gnt        <= 2'b00;
      sel        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      hold_cnt_r <= next_cnt_s;
      case (next_state_s)
        ST_OWN0: begin
          gnt    <= 2'b01;
          sel    <= 1'b0;
          last_r <= 1'b0;
          busy   <= 1'b1;
        end
        ST_OWN1: begin
          gnt    <= 2'b10;
          sel    <= 1'b1;
          last_r <= 1'b1;
          busy   <= 1'b1;
        end
        default: begin
          // sel and last_r keep the most recent owner so the mux holds steady
          gnt  <= 2'b00;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter (HOLD_MAX = 4).
// A behavioural model tracks the owner and how many cycles it has held the
// mux. A compare process checks the DUT against that model on every falling
// edge. Directed steps add literal expectations. Lock coverage is included
// when ARB_LOCK_EN is defined.
module tb_mux_sel_arbiter;

  localparam int HM = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic       lock;
  logic [1:0] gnt;
  logic       sel;
  logic       busy;

  int n_cmp;
  int n_err;

  mux_sel_arbiter #(.HOLD_MAX(HM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
`ifdef ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: owner (-1 = none), cycles held, last owner, select
  int m_owner;
  int m_held;
  int m_last;
  int m_sel;

  always @(posedge clk or negedge rst_n) begin : model
    int nxt;
    int lk;
    if (!rst_n) begin
      m_owner <= -1;
      m_held  <= 0;
      m_last  <= 1;
      m_sel   <= 0;
    end else begin
`ifdef ARB_LOCK_EN
      lk = int'(lock);
`else
      lk = 0;
`endif
      nxt = m_owner;
      if (m_owner < 0) begin
        if (req == 2'b00)      nxt = -1;
        else if (req == 2'b01) nxt = 0;
        else if (req == 2'b10) nxt = 1;
        else                   nxt = 1 - m_last;
      end else if (!req[m_owner]) begin
        nxt = req[1 - m_owner] ? (1 - m_owner) : -1;
      end else if (req[1 - m_owner] && lk == 0 && m_held >= HM) begin
        nxt = 1 - m_owner;
      end
      if (nxt >= 0 && nxt == m_owner) begin
        m_held <= m_held + 1;
      end else begin
        m_held <= 1;
      end
      if (nxt >= 0) begin
        m_last <= nxt;
        m_sel  <= nxt;
      end
      m_owner <= nxt;
    end
  end

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    logic [1:0] eg;
    eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    check("model_gnt", gnt, eg);
    check("model_sel", {1'b0, sel}, 2'(m_sel));
    check("model_busy", {1'b0, busy}, {1'b0, (m_owner >= 0)});
    check("onehot", {1'b0, (gnt == 2'b11)}, 2'b00);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [1:0] eg, input logic es, input logic eb);
    check({name, "_gnt"}, gnt, eg);
    check({name, "_sel"}, {1'b0, sel}, {1'b0, es});
    check({name, "_busy"}, {1'b0, busy}, {1'b0, eb});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 2'b00;
    lock  = 1'b0;
    #12;
    expect_out("reset", 2'b00, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    // Contention from reset: 01 x4, 10 x4, 01 x4, 10 x4
    req = 2'b11;
    for (int k = 0; k < 16; k++) begin
      step();
      if (((k / 4) % 2) == 0) expect_out("contend", 2'b01, 1'b0, 1'b1);
      else                    expect_out("contend", 2'b10, 1'b1, 1'b1);
    end
    req = 2'b00;
    step();
    expect_out("idle_keep_sel", 2'b00, 1'b1, 1'b0);

    // Single source for 10 cycles, then idle with sel held at 0
    req = 2'b01;
    for (int k = 0; k < 10; k++) begin
      step();
      expect_out("single", 2'b01, 1'b0, 1'b1);
    end
    req = 2'b00;
    step();
    expect_out("single_idle", 2'b00, 1'b0, 1'b0);

    // Early release: owner 0 drops after 2 cycles while source 1 waits
    req = 2'b01;
    step();
    req = 2'b11;
    step();
    expect_out("early_pre", 2'b01, 1'b0, 1'b1);
    req = 2'b10;
    step();
    expect_out("early_handover", 2'b10, 1'b1, 1'b1);
    req = 2'b00;
    step();

    // Saturation: long solo ownership, then the other side requests
    req = 2'b01;
    for (int k = 0; k < 8; k++) step();
    expect_out("sat_hold", 2'b01, 1'b0, 1'b1);
    req = 2'b11;
    step();
    expect_out("sat_rotate", 2'b10, 1'b1, 1'b1);

    // Hold limit coinciding with owner dropping: still hands to other side
    step(); step(); step();
    req = 2'b01;
    step();
    expect_out("limit_drop", 2'b01, 1'b0, 1'b1);

    // Asynchronous reset mid-grant
    req = 2'b11;
    step();
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 2'b00, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    expect_out("after_reset", 2'b01, 1'b0, 1'b1);

`ifdef ARB_LOCK_EN
    lock = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      expect_out("lock_hold", 2'b01, 1'b0, 1'b1);
    end
    lock = 1'b0;
    step();
    expect_out("lock_release", 2'b10, 1'b1, 1'b1);
`endif

    req = 2'b00;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
